// File: rtl/fifo_hdl_pkg.sv
// Shared types for the fifo_hdl read-side blocks.
package fifo_hdl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2
  } rdr_state_e;

endpackage

// File: rtl/fifo_sync_buf.sv
// Single-clock FIFO with occupancy count, used as the burst reader's output buffer.
// DEPTH must be a power of two; the extra pointer bit separates full from empty.
module fifo_sync_buf #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst consumer for the fifo_hdl read port: pops BURST words (or a flushed remainder)
// and replays them as a valid/ready stream tagged with a last-of-burst marker.
module fifo_burst_reader
  import fifo_hdl_pkg::*;
#(
  parameter int DSIZE      = 8,
  parameter int CSIZE      = 5,
  parameter int BURST      = 4,
  parameter int OBUF_DEPTH = 4
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  output logic             fifo_rd_en,
  input  logic [DSIZE-1:0] fifo_rd_data,
  input  logic [CSIZE-1:0] fifo_rd_count,
  input  logic             fifo_empty,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic             m_last,
  output logic             busy,
  output logic [15:0]      burst_cnt
);

  localparam int OW = $clog2(OBUF_DEPTH) + 1;
  localparam logic [CSIZE-1:0] BURST_C = CSIZE'(BURST);

  rdr_state_e       state;
  rdr_state_e       state_next;
  logic             flush_pend;
  logic             flush_pend_next;
  logic [CSIZE-1:0] issued;
  logic [CSIZE-1:0] len;
  logic             inflight;
  logic             inflight_last;
  logic             start_full;
  logic             start_flush;
  logic             credit;

  logic [DSIZE:0]   obuf_rd_data;
  logic             obuf_empty;
  logic [OW-1:0]    obuf_count;

  assign start_full  = (fifo_rd_count >= BURST_C);
  assign start_flush = !start_full && flush_pend && !fifo_empty;
  // Reads still in flight must have a reserved slot, so the buffer can never overflow.
  assign credit      = (obuf_count + OW'(inflight)) < OW'(OBUF_DEPTH);

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_full || start_flush) state_next = READ;
      READ: if (issued == len) state_next = WAIT;
      WAIT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_en = (state == READ) && (issued < len) && !fifo_empty && credit;
    busy       = (state != IDLE);
  end

  // A flush seen in IDLE with nothing buffered is simply dropped.
  always_comb begin
    flush_pend_next = flush_pend;
    if ((state == IDLE) && start_flush) begin
      flush_pend_next = 1'b0;
    end
    if (flush) begin
      flush_pend_next = !((state == IDLE) && fifo_empty);
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      flush_pend    <= 1'b0;
      issued        <= '0;
      len           <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      burst_cnt     <= '0;
    end else begin
      flush_pend    <= flush_pend_next;
      inflight      <= fifo_rd_en;
      inflight_last <= fifo_rd_en && ((issued + CSIZE'(1)) == len);
      if (state == IDLE) begin
        if (start_full) begin
          len    <= BURST_C;
          issued <= '0;
        end else if (start_flush) begin
          len    <= fifo_rd_count;
          issued <= '0;
        end
      end else if (fifo_rd_en) begin
        issued <= issued + CSIZE'(1);
      end
      if (state == WAIT) begin
        burst_cnt <= burst_cnt + 16'd1;
      end
    end
  end

  fifo_sync_buf #(
    .WIDTH (DSIZE + 1),
    .DEPTH (OBUF_DEPTH)
  ) u_obuf (
    .clk     (rd_clk),
    .rst     (rd_rst),
    .wr_en   (inflight),
    .wr_data ({inflight_last, fifo_rd_data}),
    .rd_en   (m_valid && m_ready),
    .rd_data (obuf_rd_data),
    .empty   (obuf_empty),
    .count   (obuf_count)
  );

  assign m_valid = !obuf_empty;
  assign m_data  = m_valid ? obuf_rd_data[DSIZE-1:0] : '0;
  assign m_last  = m_valid ? obuf_rd_data[DSIZE] : 1'b0;

endmodule
